// File: rtl/lexington.sv
// Lexington core control encodings: ALU operation select and shifter mode.
package lexington;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SGE  = 4'b1010,
    ALU_SGEU = 4'b1011,
    ALU_SRA  = 4'b1101,
    ALU_NOP  = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_t;
endpackage

// File: rtl/rv32.sv
// Base RV32 word types shared across the Lexington datapath.
package rv32;
  typedef logic        [31:0] word;
  typedef logic signed [31:0] signed_word;
endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for the ALU: left logical, right logical, right arithmetic.
module alu_shifter
  import rv32::*;
  import lexington::*;
(
  input  signed_word       a_i,
  input  logic       [4:0] shamt_i,
  input  shift_t           sh_type_i,
  output signed_word       y_o
);

  always_comb begin
    // NOTE: assign a default before the case so every path drives y_o and no latch is inferred.
    y_o = a_i;
    case (sh_type_i)
      SH_SLL:  y_o = a_i << shamt_i;
      SH_SRL:  y_o = signed_word'(word'(a_i) >> shamt_i);
      SH_SRA:  y_o = a_i >>> shamt_i;
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// Single-cycle RV32 execute-stage ALU with combinational and registered outputs.
module alu_unit
  import rv32::*;
  import lexington::*;
(
  input  logic       clk,
  input  logic       rst,
  input  signed_word src1,
  input  signed_word src2,
  input  alu_op_t    alu_op,
  output signed_word result,
  output logic       zero,
  output signed_word result_q,
  output logic       zero_q
);

  shift_t     sh_type;
  signed_word sh_result;

  // Any non-shift op selects SRL; the shifter output is ignored in that case.
  assign sh_type = (alu_op == ALU_SLL) ? SH_SLL :
                   (alu_op == ALU_SRA) ? SH_SRA : SH_SRL;

  alu_shifter u_shifter (
    .a_i       (src1),
    .shamt_i   (src2[4:0]),
    .sh_type_i (sh_type),
    .y_o       (sh_result)
  );

  always_comb begin
    result = src1;
    case (alu_op)
      ALU_ADD:                   result = src1 + src2;
      ALU_SUB:                   result = src1 - src2;
      ALU_SLL, ALU_SRL, ALU_SRA: result = sh_result;
      ALU_SLT:                   result = signed_word'({31'd0, src1 < src2});
      ALU_SLTU:                  result = signed_word'({31'd0, word'(src1) < word'(src2)});
      ALU_SGE:                   result = signed_word'({31'd0, src1 >= src2});
      ALU_SGEU:                  result = signed_word'({31'd0, word'(src1) >= word'(src2)});
      ALU_XOR:                   result = src1 ^ src2;
      ALU_OR:                    result = src1 | src2;
      ALU_AND:                   result = src1 & src2;
      ALU_NOP:                   result = src1;
      default:                   result = src1;
    endcase
  end

  assign zero = (result == '0);

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result;
      zero_q   <= zero;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, reset check, random pipeline check.
module tb_alu_unit;
  import rv32::*;
  import lexington::*;

  logic       clk;
  logic       rst;
  signed_word src1;
  signed_word src2;
  alu_op_t    alu_op;
  signed_word result;
  logic       zero;
  signed_word result_q;
  logic       zero_q;

  int total = 0;
  int bad   = 0;

  alu_unit dut (
    .clk      (clk),
    .rst      (rst),
    .src1     (src1),
    .src2     (src2),
    .alu_op   (alu_op),
    .result   (result),
    .zero     (zero),
    .result_q (result_q),
    .zero_q   (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic  [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: literal op codes, shifts built from a 64-bit window.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ext;
    logic [4:0]  sh;
    logic        slt;
    logic        sltu;
    sh   = b[4:0];
    sltu = (a < b);
    slt  = (a[31] != b[31]) ? a[31] : sltu;
    case (op)
      4'b0000: model = a + b;
      4'b1000: model = a - b;
      4'b0001: model = a << sh;
      4'b0101: model = a >> sh;
      4'b1101: begin
        ext   = {{32{a[31]}}, a} >> sh;
        model = ext[31:0];
      end
      4'b0010: model = {31'd0, slt};
      4'b0011: model = {31'd0, sltu};
      4'b1010: model = {31'd0, ~slt};
      4'b1011: model = {31'd0, ~sltu};
      4'b0100: model = a ^ b;
      4'b0110: model = a | b;
      4'b0111: model = a & b;
      default: model = a;
    endcase
  endfunction

  localparam int NV = 22;
  vec_t vecs[NV];

  initial begin
    logic [31:0] exp_prev;
    logic [3:0]  rop;

    vecs[0]  = '{"add_wrap",  4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[1]  = '{"sub_wrap",  4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{"slt_neg",   4'b0010, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[3]  = '{"sltu_big",  4'b0011, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[4]  = '{"sge_neg",   4'b1010, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[5]  = '{"sgeu_big",  4'b1011, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[6]  = '{"sge_eq",    4'b1010, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1'b0};
    vecs[7]  = '{"slt_eq",    4'b0010, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
    vecs[8]  = '{"sll_4",     4'b0001, 32'h8000_00F0, 32'hFFFF_FFE4, 32'h0000_0F00, 1'b0};
    vecs[9]  = '{"srl_4",     4'b0101, 32'h8000_00F0, 32'hFFFF_FFE4, 32'h0800_000F, 1'b0};
    vecs[10] = '{"sra_4",     4'b1101, 32'h8000_00F0, 32'hFFFF_FFE4, 32'hF800_000F, 1'b0};
    vecs[11] = '{"and",       4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    vecs[12] = '{"or",        4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0};
    vecs[13] = '{"xor",       4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
    vecs[14] = '{"nop",       4'b1111, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0};
    vecs[15] = '{"inv_1001",  4'b1001, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0};
    vecs[16] = '{"inv_1100",  4'b1100, 32'h1234_5678, 32'h0000_0003, 32'h1234_5678, 1'b0};
    vecs[17] = '{"inv_1110",  4'b1110, 32'h0000_0000, 32'h0000_0003, 32'h0000_0000, 1'b1};
    vecs[18] = '{"sra_31",    4'b1101, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0};
    vecs[19] = '{"srl_31",    4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0};
    vecs[20] = '{"sll_32ign", 4'b0001, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0};
    vecs[21] = '{"xor_self",  4'b0100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1};

    // Reset with non-zero inputs present: reset must win over capture.
    rst    = 1'b1;
    src1   = 32'h1234_5678;
    src2   = 32'h0000_0001;
    alu_op = ALU_ADD;
    @(posedge clk);
    #1;
    check("rst_result_q", result_q, 32'h0);
    check("rst_zero_q", {31'd0, zero_q}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      src1   = vecs[i].a;
      src2   = vecs[i].b;
      alu_op = alu_op_t'(vecs[i].op);
      #1;
      check({vecs[i].name, "_res"}, result, vecs[i].exp_res);
      check({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, vecs[i].exp_zero});
      @(negedge clk);
    end

    // Registered path: one-cycle latency after the last table vector.
    src1   = 32'h0000_0010;
    src2   = 32'h0000_0010;
    alu_op = ALU_SUB;
    @(posedge clk);
    #1;
    check("reg_sub_q", result_q, 32'h0);
    check("reg_sub_zero_q", {31'd0, zero_q}, 32'h1);

    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      rop    = 4'($urandom_range(0, 15));
      src1   = $urandom;
      src2   = (i % 4 == 0) ? src1 : $urandom;
      alu_op = alu_op_t'(rop);
      #1;
      exp_prev = model(rop, src1, src2);
      check("rand_res", result, exp_prev);
      check("rand_zero", {31'd0, zero}, {31'd0, exp_prev == 32'h0});
      @(posedge clk);
      #1;
      check("rand_result_q", result_q, exp_prev);
      check("rand_zero_q", {31'd0, zero_q}, {31'd0, exp_prev == 32'h0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

Single-cycle 32-bit integer ALU for the Lexington RV32 core's execute stage. It computes one of twelve arithmetic, logic, shift or compare operations on two 32-bit operands, selected by a 4-bit `alu_op_t` code, and flags a zero result for branch resolution. The primary outputs are purely combinational. A registered copy of them is also provided for pipelined consumers.

## Interface
Parameters: none. Width is fixed by `rv32::signed_word` (32 bits).

Ports:
- `clk` — input, 1 bit. Clock; used only by the registered outputs.
- `rst` — input, 1 bit. Reset, synchronous, active-high.
- `src1` — input, 32 bits (`rv32::signed_word`). Operand A.
- `src2` — input, 32 bits (`rv32::signed_word`). Operand B; bits [4:0] are the shift amount for shift ops.
- `alu_op` — input, 4 bits (`lexington::alu_op_t`). Operation select.
- `result` — output, 32 bits (`rv32::signed_word`). Combinational result.
- `zero` — output, 1 bit. Combinational; 1 iff `result == 0`.
- `result_q` — output, 32 bits. `result` registered on rising `clk`.
- `zero_q` — output, 1 bit. `zero` registered on rising `clk`.

## Operation
Encoding of `alu_op_t` and the result each code produces:
- ALU_ADD 4'b0000: src1 + src2, wrap modulo 2^32.
- ALU_SLL 4'b0001: src1 << src2[4:0].
- ALU_SLT 4'b0010: 1 if signed src1 < src2, else 0.
- ALU_SLTU 4'b0011: 1 if unsigned src1 < src2, else 0.
- ALU_XOR 4'b0100: src1 ^ src2.
- ALU_SRL 4'b0101: logical shift right by src2[4:0], zero fill.
- ALU_OR 4'b0110: src1 | src2.
- ALU_AND 4'b0111: src1 & src2.
- ALU_SUB 4'b1000: src1 − src2, wrap modulo 2^32.
- ALU_SGE 4'b1010: 1 if signed src1 ≥ src2, else 0.
- ALU_SGEU 4'b1011: 1 if unsigned src1 ≥ src2, else 0.
- ALU_SRA 4'b1101: arithmetic shift right by src2[4:0], sign fill.
- ALU_NOP 4'b1111: result = src1.

Undefined codes (4'b1001, 4'b1100, 4'b1110): result = src1, identical to NOP.

General rules:
- Compare results are zero-extended to 32 bits: 32'h0000_0001 or 32'h0000_0000.
- src2[31:5] are ignored by all shift ops.
- No overflow or carry flags.
- `zero` is derived from the final `result` for every op, including compares and NOP.
- Output must never be X or Z for any fully defined input.

## Timing
- `result` and `zero`: zero latency. Combinational from `src1`, `src2`, `alu_op`, with no dependence on `clk` or `rst`.
- `result_q` and `zero_q`: one-cycle latency, updated on each rising `clk`.
- Reset, on a rising `clk` with `rst=1`: `result_q` = 0 and `zero_q` = 1. Reset has priority over capture.
- Registered outputs have no enable; they capture every cycle.

## Structure
Package placement:
- `rv32` package: `word` (unsigned 32-bit) and `signed_word` (signed 32-bit).
- `lexington` package: `alu_op_t` enum with the encoding above. Decode logic must not use literal op codes.

Implementation:
- One `always_comb` case on `alu_op`, plus one `always_ff` for the registered outputs.
- Unsigned compares use `rv32::word` casts.
- Optional sub-module `alu_shifter`, handling SLL, SRL and SRA from a 2-bit shift-type select.

## Test plan
- ADD/SUB wrap: src1=32'hFFFF_FFFF, src2=1, ADD → result 0, zero=1. src1=0, src2=1, SUB → 32'hFFFF_FFFF, zero=0.
- Signed vs unsigned compare: src1=32'h8000_0000, src2=1.
  - SLT → 1, SLTU → 0.
  - SGE → 0, SGEU → 1.
  - Equal operands: SGE → 1 and SLT → 0.
- Shifts: src1=32'h8000_00F0, src2=32'hFFFF_FFE4 (shift amount 4).
  - SLL → 32'h0000_0F00.
  - SRL → 32'h0800_000F.
  - SRA → 32'hF800_000F.
- Logic: src1=32'hF0F0_F0F0, src2=32'hFF00_FF00.
  - AND → 32'hF000_F000.
  - OR → 32'hFFF0_FFF0.
  - XOR → 32'h0FF0_0FF0.
- NOP and invalid: src1=32'h1234_5678 with ALU_NOP, then with 4'b1001 → both give 32'h1234_5678, zero=0.
- Registers and randomized check:
  - Assert `rst` for one cycle → `result_q`=0, `zero_q`=1.
  - Then run 512 cycles of random src1, src2 and alu_op. Each cycle, `result` must match the reference model and `result_q` must equal the previous cycle's `result`.
